fb_reader: RTL and testbench
============================

// Module: fb_reader
// PURPOSE
// Wishbone master that reads the framebuffer written by the pattern/pixel writers, in raster order, into a local FIFO.
// Presents pixels on a valid/ready stream to the video timing/output stage.
// One address per pixel, 4 bytes per pixel, RGB in bits [23:0].
// Sits between the SDRAM Wishbone arbiter and the display pipeline.
// PARAMETERS
// HDISP        800  active pixels per line
// VDISP        480  active lines per frame
// FIFO_DEPTH   256  pixel FIFO entries (power of 2, >=4)
// PORTS
// wshb_if_rd.clk     in   1   system clock, all logic on rising edge
// wshb_if_rd.rst     in   1   synchronous active-high reset
// wshb_if_rd         master  -  Wishbone interface, modport master (cyc,stb,we,sel,adr,dat_sm,ack)
// resync             in   1   1-cycle pulse: restart reading at frame start, flush FIFO
// pix_data           out  24  RGB pixel {R,G,B}
// pix_sof            out  1   pix_data is pixel 0 of a frame
// pix_valid          out  1   stream valid
// pix_ready          in   1   stream ready; transfer when valid&&ready
// fifo_level         out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
// underrun_cnt       out  16  only with FB_READER_UNDERRUN_EN (see CONFIGURATION)
// BEHAVIOUR
// Reset: cyc=stb=we=0, sel=4'hF, adr=0, FIFO empty, pix_valid=0, pix_sof=0, fifo_level=0, FSM=REQ.
// Wishbone is classic, one transaction outstanding.
//   - Once stb rises, cyc/stb/adr stay stable until the cycle ack=1.
//   - we is always 0; dat_ms is driven 0.
// FSM states:
//   - REQ: cyc=stb=1. On ack:
//       push {adr==0, dat_sm[23:0]} into the FIFO.
//       adr <= (adr >= 4*(HDISP*VDISP-1)) ? 0 : adr+4.
//       If level after the push is >= FIFO_DEPTH-1, go to HOLD with cyc=stb=0; else stay in REQ (back-to-back).
//   - HOLD: cyc=stb=0. Return to REQ when level <= FIFO_DEPTH-2.
//   - DRAIN: entered on resync while stb=1. Hold the request until ack, discard dat_sm, then go to FLUSH.
//   - FLUSH: 1 cycle. FIFO cleared, adr<=0, then go to REQ.
//   - resync in REQ with no pending ack, or in HOLD: go directly to FLUSH.
//   - resync while already in DRAIN/FLUSH: ignored.
// Latency:
//   - First stb is the first cycle after rst deasserts.
//   - Pixel acked at edge N is visible on pix_valid after edge N (FIFO is first-word-fall-through).
// Stream: pix_data/pix_sof are stable while pix_valid && !pix_ready.
// Push and pop in the same cycle: level unchanged. The FIFO never overflows by construction.
// Empty FIFO: pix_valid=0. Data is never repeated or invented.
// Reset mid-transaction: cyc/stb drop immediately; the ack of the aborted cycle is not expected.
// CONFIGURATION
// FB_READER_UNDERRUN_EN defined:
//   - underrun_cnt counts cycles with pix_ready=1 && pix_valid=0.
//   - Saturates at 16'hFFFF; cleared by rst and by resync.
// FB_READER_UNDERRUN_EN undefined: underrun_cnt port and counter are absent.
// STRUCTURE
// Package video_pkg: typedef logic [23:0] rgb_t; localparam BYTES_PER_PIXEL=4; typedef enum {REQ,HOLD,DRAIN,FLUSH} fbr_state_t.
// Sub-module sync_fifo #(WIDTH=25, DEPTH=FIFO_DEPTH):
//   - FWFT, single clock, sync clear, level output.
//   - Instantiated once; all Wishbone/FSM logic lives in fb_reader.
// TESTING
// 1. Reset release, slave acks every cycle, pix_ready=0:
//      exactly FIFO_DEPTH-1=255 acks, then stb=0; fifo_level=255; first pixel has pix_sof=1 and adr 0.
// 2. pix_ready=1 continuous with 0-wait slave, HDISP=4/VDISP=2:
//      adr sequence 0,4,..,28,0; pix_sof=1 on pixels 0 and 8 only.
// 3. Slave with 3-cycle ack latency: cyc/stb/adr held stable until ack; dat_sm 24'h123456 appears as pix_data.
// 4. resync while stb=1 and ack pending:
//      DRAIN until ack, data dropped, FIFO empty, next request at adr 0 with pix_sof=1.
// 5. pix_ready toggling 1/0 at random with a randomly stalling slave:
//      output sequence equals the memory contents in order, no loss or duplication, level never > FIFO_DEPTH.
// 6. With FB_READER_UNDERRUN_EN, slave never acks, pix_ready=1 for 10 cycles:
//      underrun_cnt=10; after resync, 0.

Source files
------------

// File: rtl/video_pkg.sv
// video_pkg: pixel, framebuffer-reader state and FIFO entry types shared by the display path.
// Rev 1.0
`default_nettype none

package video_pkg;

  typedef logic [23:0] rgb_t;

  localparam int BYTES_PER_PIXEL = 4;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } fbr_state_t;

  // One FIFO entry: start-of-frame flag alongside the pixel colour.
  typedef struct packed {
    logic sof;
    rgb_t rgb;
  } fb_pix_t;

endpackage

`default_nettype wire

// File: rtl/wshb_if.sv
// wshb_if: classic Wishbone bus bundle with the system clock and synchronous reset.
// Rev 1.0
`default_nettype none

interface wshb_if (
  input logic clk,
  input logic rst
);

  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic        ack;

  modport master (
    input  clk, rst, dat_sm, ack,
    output cyc, stb, we, sel, adr, dat_ms
  );

  modport slave (
    input  clk, rst, cyc, stb, we, sel, adr, dat_ms,
    output dat_sm, ack
  );

endinterface

`default_nettype wire

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO with synchronous clear and occupancy output.
// Rev 1.0
`default_nettype none

module sync_fifo #(
  parameter  int WIDTH = 25,
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_d;
  logic             w_push;
  logic             w_pop;

  assign w_push  = push_i && (level_q != LW'(DEPTH));
  assign w_pop   = pop_i && (level_q != '0);
  assign level_d = level_q + LW'(w_push) - LW'(w_pop);

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push && !clr_i && !rst) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule

`default_nettype wire

// File: rtl/fb_reader.sv
// fb_reader: Wishbone master streaming the framebuffer in raster order through a pixel FIFO.
// Rev 1.0 -- define FB_READER_UNDERRUN_EN to add the underrun_cnt output.
`default_nettype none

module fb_reader
  import video_pkg::*;
#(
  parameter  int HDISP      = 800,
  parameter  int VDISP      = 480,
  parameter  int FIFO_DEPTH = 256,
  localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
  wshb_if.master         wshb_if_rd,
  input  logic           resync,
  output rgb_t           pix_data,
  output logic           pix_sof,
  output logic           pix_valid,
  input  logic           pix_ready,
  output logic [LW-1:0]  fifo_level
`ifdef FB_READER_UNDERRUN_EN
  ,
  output logic [15:0]    underrun_cnt
`endif
);

  localparam logic [31:0] LAST_ADR = 32'(BYTES_PER_PIXEL * (HDISP * VDISP - 1));

  fbr_state_t    state_q;
  logic          cyc_q;
  logic [31:0]   adr_q;
  logic [31:0]   adr_d;
  logic          w_ack;
  logic          w_pop;
  logic          w_push;
  logic          w_clr;
  logic [LW-1:0] w_level_after;
  fb_pix_t       w_fifo_in;
  fb_pix_t       w_fifo_out;
  logic          w_empty;

  assign wshb_if_rd.cyc    = cyc_q;
  assign wshb_if_rd.stb    = cyc_q;
  assign wshb_if_rd.we     = 1'b0;
  assign wshb_if_rd.sel    = 4'hF;
  assign wshb_if_rd.adr    = adr_q;
  assign wshb_if_rd.dat_ms = '0;

  assign w_ack  = cyc_q && wshb_if_rd.ack;
  assign w_pop  = pix_valid && pix_ready;
  assign w_push = (state_q == REQ) && w_ack && !resync;
  // Clear as soon as a resync is accepted so stale pixels never reach the stream.
  assign w_clr  = (resync && ((state_q == REQ) || (state_q == HOLD))) || (state_q == FLUSH);

  assign w_level_after = fifo_level + LW'(w_push) - LW'(w_pop);
  assign adr_d         = (adr_q >= LAST_ADR) ? '0 : adr_q + 32'd4;

  assign w_fifo_in.sof = (adr_q == '0);
  assign w_fifo_in.rgb = wshb_if_rd.dat_sm[23:0];

  always_ff @(posedge wshb_if_rd.clk) begin
    if (wshb_if_rd.rst) begin
      state_q <= REQ;
      cyc_q   <= 1'b0;
      adr_q   <= '0;
    end else begin
      case (state_q)
        REQ: begin
          if (resync) begin
            if (cyc_q && !wshb_if_rd.ack) begin
              state_q <= DRAIN;
            end else begin
              state_q <= FLUSH;
              cyc_q   <= 1'b0;
            end
          end else begin
            cyc_q <= 1'b1;
            if (w_ack) begin
              adr_q <= adr_d;
              if (w_level_after >= LW'(FIFO_DEPTH - 1)) begin
                state_q <= HOLD;
                cyc_q   <= 1'b0;
              end
            end
          end
        end
        HOLD: begin
          if (resync) begin
            state_q <= FLUSH;
          end else if (fifo_level <= LW'(FIFO_DEPTH - 2)) begin
            state_q <= REQ;
            cyc_q   <= 1'b1;
          end
        end
        DRAIN: begin
          if (w_ack) begin
            state_q <= FLUSH;
            cyc_q   <= 1'b0;
          end
        end
        FLUSH: begin
          adr_q   <= '0;
          state_q <= REQ;
          cyc_q   <= 1'b1;
        end
        default: begin
          state_q <= REQ;
          cyc_q   <= 1'b0;
        end
      endcase
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fb_pix_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (wshb_if_rd.clk),
    .rst     (wshb_if_rd.rst),
    .clr_i   (w_clr),
    .push_i  (w_push),
    .data_i  (w_fifo_in),
    .pop_i   (w_pop),
    .data_o  (w_fifo_out),
    .empty_o (w_empty),
    .level_o (fifo_level)
  );

  assign pix_valid = !w_empty;
  assign pix_data  = w_fifo_out.rgb;
  assign pix_sof   = w_fifo_out.sof;

`ifdef FB_READER_UNDERRUN_EN
  logic [15:0] underrun_q;

  always_ff @(posedge wshb_if_rd.clk) begin
    if (wshb_if_rd.rst || resync) begin
      underrun_q <= '0;
    end else if (pix_ready && !pix_valid && (underrun_q != 16'hFFFF)) begin
      underrun_q <= underrun_q + 16'd1;
    end
  end

  assign underrun_cnt = underrun_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fb_reader.sv
// tb_fb_reader: directed and randomised checks of fb_reader against a frame-order pixel model.
// Rev 1.0
`default_nettype none

module tb_fb_reader;
  import video_pkg::*;

  localparam int HD    = 4;
  localparam int VD    = 2;
  localparam int NPIX  = HD * VD;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wshb_if wb (.clk(clk), .rst(rst));

  logic          resync    = 1'b0;
  logic          pix_ready = 1'b0;
  rgb_t          pix_data;
  logic          pix_sof;
  logic          pix_valid;
  logic [LW-1:0] fifo_level;
`ifdef FB_READER_UNDERRUN_EN
  logic [15:0]   underrun_cnt;
`endif

  fb_reader #(
    .HDISP      (HD),
    .VDISP      (VD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .wshb_if_rd (wb),
    .resync     (resync),
    .pix_data   (pix_data),
    .pix_sof    (pix_sof),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .fifo_level (fifo_level)
`ifdef FB_READER_UNDERRUN_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Framebuffer contents: pixel i lives at byte address 4*i.
  rgb_t mem [NPIX];
  initial begin
    for (int i = 0; i < NPIX; i++) mem[i] = 24'h102030 + rgb_t'(i) * 24'h010101;
  end

  // Wishbone slave: decides ack for the next edge, 1 time unit after the falling edge.
  bit          slave_en = 1'b1;
  bit          rnd_lat  = 1'b0;
  bit          chk_adr  = 1'b1;
  int          lat      = 0;
  int          cur_lat  = 0;
  int          wcnt     = 0;
  int          ack_cnt  = 0;
  logic [31:0] exp_adr  = '0;
  logic [31:0] prev_adr = '0;
  bit          prev_pending = 1'b0;

  always @(negedge clk) begin
    #1;
    if (rst) begin
      wb.ack       = 1'b0;
      wb.dat_sm    = '0;
      wcnt         = 0;
      cur_lat      = lat;
      exp_adr      = '0;
      prev_pending = 1'b0;
    end else begin
      if (prev_pending) begin
        check("wb_hold_stb", 32'(wb.stb), 32'd1);
        check("wb_hold_adr", wb.adr, prev_adr);
      end
      if (wb.cyc && wb.stb && slave_en) begin
        if (wcnt >= cur_lat) begin
          wb.ack    = 1'b1;
          wb.dat_sm = {8'hAB, mem[wb.adr[4:2]]};
          wcnt      = 0;
          ack_cnt++;
          if (chk_adr) begin
            check("wb_adr_seq", wb.adr, exp_adr);
            exp_adr = (exp_adr + 32'd4) & 32'h1F;
          end
          cur_lat = rnd_lat ? int'($urandom_range(0, 3)) : lat;
        end else begin
          wb.ack = 1'b0;
          wcnt++;
        end
      end else begin
        wb.ack = 1'b0;
        wcnt   = 0;
      end
      prev_pending = wb.cyc && wb.stb && !wb.ack;
      prev_adr     = wb.adr;
    end
  end

  // Stream model: transfers must walk the frame in order and restart at pixel 0 on resync.
  int   exp_idx  = 0;
  int   xfer_cnt = 0;
  int   sof_cnt  = 0;
  bit   prev_stall = 1'b0;
  logic [24:0] prev_word = '0;

  always @(negedge clk) begin
    #2;
    if (rst) begin
      exp_idx    = 0;
      xfer_cnt   = 0;
      sof_cnt    = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stream_hold_valid", 32'(pix_valid), 32'd1);
        check("stream_hold_data", 32'({pix_sof, pix_data}), 32'(prev_word));
      end
      check("valid_vs_level", 32'(pix_valid), 32'(fifo_level != '0));
      check("level_bound", 32'(fifo_level <= LW'(DEPTH)), 32'd1);
      if (pix_valid && pix_ready) begin
        check("pix_data", 32'(pix_data), 32'(mem[exp_idx]));
        check("pix_sof", 32'(pix_sof), 32'(exp_idx == 0));
        if (pix_sof) sof_cnt++;
        exp_idx = (exp_idx + 1) % NPIX;
        xfer_cnt++;
      end
      prev_stall = pix_valid && !pix_ready && !resync;
      prev_word  = {pix_sof, pix_data};
      if (resync) exp_idx = 0;
    end
  end

  task automatic wait_acks(input int n, input string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #3;
      if (ack_cnt >= n) return;
    end
    check(name, 32'(ack_cnt), 32'(n));
  endtask

  task automatic do_reset(input int l, input bit rnd);
    @(negedge clk);
    rst       = 1'b1;
    pix_ready = 1'b0;
    resync    = 1'b0;
    lat       = l;
    rnd_lat   = rnd;
    repeat (3) @(negedge clk);
    ack_cnt = 0;
    rst     = 1'b0;
  endtask

  initial begin
    // 1: fill to DEPTH-1 with no consumer, then the master parks.
    do_reset(0, 1'b0);
    @(negedge clk); #3;
    check("first_stb", 32'(wb.stb), 32'd1);
    check("wb_we", 32'(wb.we), 32'd0);
    check("wb_sel", 32'(wb.sel), 32'hF);
    repeat (30) @(negedge clk);
    #3;
    check("fill_acks", 32'(ack_cnt), 32'd7);
    check("fill_stb_low", 32'(wb.stb), 32'd0);
    check("fill_level", 32'(fifo_level), 32'd7);
    check("fill_valid", 32'(pix_valid), 32'd1);
    check("fill_sof", 32'(pix_sof), 32'd1);
    check("fill_first_pix", 32'(pix_data), 32'h102030);

    // 2: continuous consumer across a frame wrap.
    do_reset(0, 1'b0);
    pix_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (xfer_cnt >= 10) break;
    end
    pix_ready = 1'b0;
    #3;
    check("wrap_xfers", 32'(xfer_cnt), 32'd10);
    check("wrap_sof_count", 32'(sof_cnt), 32'd2);

    // 3: slow slave, data lane extraction.
    @(negedge clk);
    rst    = 1'b1;
    mem[0] = 24'h123456;
    do_reset(3, 1'b0);
    wait_acks(1, "slow_ack_timeout");
    @(negedge clk); #3;
    check("slow_valid", 32'(pix_valid), 32'd1);
    check("slow_pix", 32'(pix_data), 32'h123456);
    check("slow_sof", 32'(pix_sof), 32'd1);
    @(negedge clk);
    rst    = 1'b1;
    mem[0] = 24'h102030;

    // 4: resync with a request outstanding.
    chk_adr = 1'b0;
    do_reset(4, 1'b0);
    wait_acks(3, "drain_fill_timeout");
    @(negedge clk);
    resync = 1'b1;
    @(negedge clk);
    resync = 1'b0;
    #3;
    check("drain_level", 32'(fifo_level), 32'd0);
    check("drain_valid", 32'(pix_valid), 32'd0);
    check("drain_stb_held", 32'(wb.stb), 32'd1);
    wait_acks(4, "drain_ack_timeout");
    @(negedge clk); #3;
    check("flush_stb_low", 32'(wb.stb), 32'd0);
    check("flush_level", 32'(fifo_level), 32'd0);
    @(negedge clk); #3;
    check("restart_stb", 32'(wb.stb), 32'd1);
    check("restart_adr", wb.adr, 32'd0);
    wait_acks(5, "restart_ack_timeout");
    @(negedge clk); #3;
    check("restart_valid", 32'(pix_valid), 32'd1);
    check("restart_sof", 32'(pix_sof), 32'd1);
    check("restart_pix", 32'(pix_data), 32'h102030);

    // 5: random back-pressure with a randomly stalling slave.
    @(negedge clk);
    chk_adr = 1'b1;
    do_reset(0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      pix_ready = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    pix_ready = 1'b0;
    #3;
    check("random_progress", 32'(xfer_cnt > 40), 32'd1);

`ifdef FB_READER_UNDERRUN_EN
    // 6: starved consumer counts underrun cycles; resync clears the count.
    slave_en = 1'b0;
    do_reset(0, 1'b0);
    @(negedge clk);
    pix_ready = 1'b1;
    repeat (10) @(negedge clk);
    pix_ready = 1'b0;
    #3;
    check("underrun_count", 32'(underrun_cnt), 32'd10);
    @(negedge clk);
    resync = 1'b1;
    @(negedge clk);
    resync = 1'b0;
    #3;
    check("underrun_cleared", 32'(underrun_cnt), 32'd0);
    @(negedge clk);
    rst      = 1'b1;
    slave_en = 1'b1;
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
